// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
// mc_ctrl_pkg : shared types and encodings for the multicycle MIPS controller
// Rev 1.0
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Raw per-state control word, before reset and memory-wait gating
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
  } ctrl_word_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_control_fsm_if.sv
// ============================================================================
// mc_control_fsm_if : IR/flag inputs and datapath control outputs of the FSM
// Rev 1.0
// ============================================================================
`default_nettype none

interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       memwrite;
  logic       irwrite;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic       pcen;
  logic       illegal_op;
  logic [3:0] state_o;

  modport master (
    input  opcode, zero, mem_ready,
    output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state_o
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, aluop, pcsrc, pcen, illegal_op, state_o
  );
endinterface

`default_nettype wire

// File: rtl/mc_ctrl_outdec.sv
// ============================================================================
// mc_ctrl_outdec : Moore decode from controller state to raw control word
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    case (state)
      S_FETCH: begin
        cw.irwrite = 1'b1;
        cw.pcwrite = 1'b1;
        cw.alusrcb = SRCB_FOUR;
      end
      // Branch target is precomputed here while the opcode is decoded
      S_DECODE: cw.alusrcb = SRCB_IMM_SH2;
      S_MEMADR: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      S_MEMRD: cw.iord = 1'b1;
      S_MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cw.iord     = 1'b1;
        cw.memwrite = 1'b1;
      end
      S_EXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_REG;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw.regdst   = 1'b1;
        cw.regwrite = 1'b1;
      end
      S_BRANCH: begin
        cw.alusrca = 1'b1;
        cw.aluop   = ALUOP_SUB;
        cw.pcsrc   = PCSRC_ALUOUT;
        cw.branch  = 1'b1;
      end
      S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: cw.regwrite = 1'b1;
      S_JUMP: begin
        cw.pcsrc   = PCSRC_JUMP;
        cw.pcwrite = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// ============================================================================
// mc_control_fsm : multicycle MIPS main control FSM; MC_MEM_WAIT_EN adds memory wait states
// Rev 1.0
// ============================================================================
`default_nettype none

module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mc_control_fsm_if.master bus
);

  state_t     r_state;
  state_t     w_next_state;
  ctrl_word_t w_cw;
  logic       w_mem_ready;
  logic       w_fetch_hold;
  logic       w_illegal;
  logic       w_unused;

`ifdef MC_MEM_WAIT_EN
  assign w_mem_ready = bus.mem_ready;
`else
  assign w_mem_ready = 1'b1;
`endif

  assign w_unused = &{1'b0, bus.mem_ready, (MEM_TIMEOUT == 0)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH:  w_next_state = w_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_mem_op(bus.opcode)) begin
          w_next_state = S_MEMADR;
        end else begin
          case (bus.opcode)
            OP_RTYPE: w_next_state = S_EXEC;
            OP_BEQ:   w_next_state = S_BRANCH;
            OP_ADDI:  w_next_state = S_ADDIEX;
            OP_J:     w_next_state = S_JUMP;
            default: begin
              w_next_state = S_FETCH;
              w_illegal    = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: w_next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next_state = w_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next_state = w_mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   w_next_state = S_ALUWB;
      S_ADDIEX: w_next_state = S_ADDIWB;
      default:  w_next_state = S_FETCH;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .state (r_state),
    .cw    (w_cw)
  );

  // Strobes are qualified by rst_n so nothing fires while reset is held
  assign w_fetch_hold   = (r_state == S_FETCH) && !w_mem_ready;

  assign bus.iord       = w_cw.iord;
  assign bus.regdst     = w_cw.regdst;
  assign bus.memtoreg   = w_cw.memtoreg;
  assign bus.alusrca    = w_cw.alusrca;
  assign bus.alusrcb    = w_cw.alusrcb;
  assign bus.aluop      = w_cw.aluop;
  assign bus.pcsrc      = w_cw.pcsrc;
  assign bus.memwrite   = w_cw.memwrite & rst_n;
  assign bus.regwrite   = w_cw.regwrite & rst_n;
  assign bus.irwrite    = w_cw.irwrite & ~w_fetch_hold & rst_n;
  assign bus.pcen       = rst_n & ((w_cw.pcwrite & ~w_fetch_hold) | (w_cw.branch & bus.zero));
  assign bus.illegal_op = w_illegal & rst_n;
  assign bus.state_o    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// ============================================================================
// tb_mc_control_fsm : directed self-checking bench for mc_control_fsm
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mc_control_fsm;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_ALUWB  = 4'd7;
  localparam logic [3:0] ST_BRANCH = 4'd8;
  localparam logic [3:0] ST_ADDIEX = 4'd9;
  localparam logic [3:0] ST_ADDIWB = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mc_control_fsm_if bus ();

  mc_control_fsm #(.MEM_TIMEOUT(0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobe vector order: {irwrite, pcen, memwrite, regwrite, illegal_op}
  task automatic test_reset();
    rst_n = 1'b0;
    bus.opcode = 6'b000000;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL reset_state got %0d exp %0d", bus.state_o, ST_FETCH); end
    checks++; if ({bus.irwrite, bus.pcen, bus.memwrite, bus.regwrite, bus.illegal_op} !== 5'b00000) begin errors++; $display("FAIL reset_strobes got %b exp 00000", {bus.irwrite, bus.pcen, bus.memwrite, bus.regwrite, bus.illegal_op}); end
    checks++; if (bus.alusrcb !== 2'b01) begin errors++; $display("FAIL reset_alusrcb got %b exp 01", bus.alusrcb); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({bus.irwrite, bus.pcen} !== 2'b11) begin errors++; $display("FAIL release_fetch_strobes got %b exp 11", {bus.irwrite, bus.pcen}); end
  endtask

  task automatic test_lw();
    bus.opcode = 6'b100011;
    checks++; if (bus.alusrcb !== 2'b01 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL lw_c1 got srcb=%b rw=%b exp srcb=01 rw=0", bus.alusrcb, bus.regwrite); end
    step();
    checks++; if (bus.state_o !== ST_DECODE || bus.alusrcb !== 2'b11) begin errors++; $display("FAIL lw_c2 got st=%0d srcb=%b exp st=1 srcb=11", bus.state_o, bus.alusrcb); end
    checks++; if ({bus.irwrite, bus.pcen, bus.regwrite} !== 3'b000) begin errors++; $display("FAIL lw_c2_strobes got %b exp 000", {bus.irwrite, bus.pcen, bus.regwrite}); end
    step();
    checks++; if (bus.state_o !== ST_MEMADR || bus.alusrcb !== 2'b10 || bus.alusrca !== 1'b1) begin errors++; $display("FAIL lw_c3 got st=%0d srcb=%b srca=%b exp st=2 srcb=10 srca=1", bus.state_o, bus.alusrcb, bus.alusrca); end
    step();
    checks++; if (bus.state_o !== ST_MEMRD || bus.iord !== 1'b1 || bus.regwrite !== 1'b0) begin errors++; $display("FAIL lw_c4 got st=%0d iord=%b rw=%b exp st=3 iord=1 rw=0", bus.state_o, bus.iord, bus.regwrite); end
    step();
    checks++; if (bus.state_o !== ST_MEMWB || {bus.regwrite, bus.memtoreg, bus.regdst} !== 3'b110) begin errors++; $display("FAIL lw_c5 got st=%0d rw/m2r/rd=%b exp st=4 110", bus.state_o, {bus.regwrite, bus.memtoreg, bus.regdst}); end
    step();
    checks++; if (bus.state_o !== ST_FETCH || bus.memtoreg !== 1'b0) begin errors++; $display("FAIL lw_end got st=%0d m2r=%b exp st=0 m2r=0", bus.state_o, bus.memtoreg); end
  endtask

  task automatic test_beq(input logic z);
    bus.opcode = 6'b000100;
    bus.zero = z;
    step();
    checks++; if (bus.state_o !== ST_DECODE || bus.pcen !== 1'b0) begin errors++; $display("FAIL beq_decode got st=%0d pcen=%b exp st=1 pcen=0", bus.state_o, bus.pcen); end
    step();
    checks++; if (bus.state_o !== ST_BRANCH || bus.pcsrc !== 2'b01 || bus.aluop !== 2'b01) begin errors++; $display("FAIL beq_branch got st=%0d pcsrc=%b aluop=%b exp st=8 pcsrc=01 aluop=01", bus.state_o, bus.pcsrc, bus.aluop); end
    checks++; if (bus.pcen !== z) begin errors++; $display("FAIL beq_pcen got %b exp %b", bus.pcen, z); end
    bus.zero = ~z;
    #1;
    checks++; if (bus.pcen !== ~z) begin errors++; $display("FAIL beq_pcen_comb got %b exp %b", bus.pcen, ~z); end
    bus.zero = z;
    step();
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL beq_end got %0d exp 0", bus.state_o); end
  endtask

  task automatic test_jump();
    bus.opcode = 6'b000010;
    bus.zero = 1'b0;
    step();
    step();
    checks++; if (bus.state_o !== ST_JUMP || bus.pcsrc !== 2'b10 || bus.pcen !== 1'b1) begin errors++; $display("FAIL j_c3 got st=%0d pcsrc=%b pcen=%b exp st=11 pcsrc=10 pcen=1", bus.state_o, bus.pcsrc, bus.pcen); end
    step();
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL j_c4 got %0d exp 0", bus.state_o); end
  endtask

  task automatic test_illegal();
    bus.opcode = 6'b111111;
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL ill_fetch got %b exp 0", bus.illegal_op); end
    step();
    checks++; if (bus.state_o !== ST_DECODE || {bus.illegal_op, bus.regwrite, bus.memwrite} !== 3'b100) begin errors++; $display("FAIL ill_decode got st=%0d ill/rw/mw=%b exp st=1 100", bus.state_o, {bus.illegal_op, bus.regwrite, bus.memwrite}); end
    step();
    checks++; if (bus.state_o !== ST_FETCH || {bus.illegal_op, bus.regwrite, bus.memwrite} !== 3'b000) begin errors++; $display("FAIL ill_after got st=%0d ill/rw/mw=%b exp st=0 000", bus.state_o, {bus.illegal_op, bus.regwrite, bus.memwrite}); end
  endtask

  task automatic test_addi();
    bus.opcode = 6'b001000;
    step();
    step();
    checks++; if (bus.state_o !== ST_ADDIEX || bus.alusrca !== 1'b1 || bus.alusrcb !== 2'b10 || bus.aluop !== 2'b00) begin errors++; $display("FAIL addi_ex got st=%0d srca=%b srcb=%b aluop=%b exp 9 1 10 00", bus.state_o, bus.alusrca, bus.alusrcb, bus.aluop); end
    step();
    checks++; if (bus.state_o !== ST_ADDIWB || {bus.regwrite, bus.regdst, bus.memtoreg} !== 3'b100) begin errors++; $display("FAIL addi_wb got st=%0d rw/rd/m2r=%b exp 10 100", bus.state_o, {bus.regwrite, bus.regdst, bus.memtoreg}); end
    step();
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL addi_end got %0d exp 0", bus.state_o); end
  endtask

  task automatic test_sw();
    bus.opcode = 6'b101011;
    step();
    step();
    checks++; if (bus.state_o !== ST_MEMADR) begin errors++; $display("FAIL sw_adr got %0d exp 2", bus.state_o); end
    step();
`ifdef MC_MEM_WAIT_EN
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.state_o !== ST_MEMWR || bus.memwrite !== 1'b1) begin errors++; $display("FAIL sw_wait%0d got st=%0d mw=%b exp st=5 mw=1", i, bus.state_o, bus.memwrite); end
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
`endif
    checks++; if (bus.state_o !== ST_MEMWR || bus.memwrite !== 1'b1 || bus.iord !== 1'b1) begin errors++; $display("FAIL sw_wr got st=%0d mw=%b iord=%b exp 5 1 1", bus.state_o, bus.memwrite, bus.iord); end
    step();
    checks++; if (bus.state_o !== ST_FETCH || bus.memwrite !== 1'b0) begin errors++; $display("FAIL sw_end got st=%0d mw=%b exp 0 0", bus.state_o, bus.memwrite); end
  endtask

`ifdef MC_MEM_WAIT_EN
  task automatic test_fetch_wait();
    bus.opcode = 6'b000010;
    bus.mem_ready = 1'b0;
    #1;
    checks++; if ({bus.irwrite, bus.pcen} !== 2'b00) begin errors++; $display("FAIL fwait_gate got %b exp 00", {bus.irwrite, bus.pcen}); end
    step();
    checks++; if (bus.state_o !== ST_FETCH || {bus.irwrite, bus.pcen} !== 2'b00) begin errors++; $display("FAIL fwait_hold got st=%0d %b exp 0 00", bus.state_o, {bus.irwrite, bus.pcen}); end
    bus.mem_ready = 1'b1;
    #1;
    checks++; if ({bus.irwrite, bus.pcen} !== 2'b11) begin errors++; $display("FAIL fwait_fire got %b exp 11", {bus.irwrite, bus.pcen}); end
    step();
    step();
    step();
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL fwait_end got %0d exp 0", bus.state_o); end
  endtask
`endif

  task automatic test_rtype_reset();
    bus.opcode = 6'b000000;
    step();
    step();
    checks++; if (bus.state_o !== ST_EXEC || bus.aluop !== 2'b10 || bus.alusrcb !== 2'b00 || bus.alusrca !== 1'b1) begin errors++; $display("FAIL rt_exec got st=%0d aluop=%b srcb=%b srca=%b exp 6 10 00 1", bus.state_o, bus.aluop, bus.alusrcb, bus.alusrca); end
    step();
    checks++; if (bus.state_o !== ST_ALUWB || bus.regwrite !== 1'b1 || bus.regdst !== 1'b1) begin errors++; $display("FAIL rt_wb got st=%0d rw=%b rd=%b exp 7 1 1", bus.state_o, bus.regwrite, bus.regdst); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.state_o !== ST_FETCH || bus.regwrite !== 1'b0) begin errors++; $display("FAIL rt_abort got st=%0d rw=%b exp 0 0", bus.state_o, bus.regwrite); end
    checks++; if ({bus.irwrite, bus.pcen, bus.memwrite} !== 3'b000) begin errors++; $display("FAIL rt_abort_strobes got %b exp 000", {bus.irwrite, bus.pcen, bus.memwrite}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.state_o !== ST_FETCH || bus.irwrite !== 1'b1) begin errors++; $display("FAIL rt_rerelease got st=%0d ir=%b exp 0 1", bus.state_o, bus.irwrite); end
    step();
    checks++; if (bus.state_o !== ST_DECODE) begin errors++; $display("FAIL rt_restart got %0d exp 1", bus.state_o); end
    step();
    step();
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jump();
    test_illegal();
    test_addi();
    test_sw();
`ifdef MC_MEM_WAIT_EN
    test_fetch_wait();
`endif
    test_rtype_reset();
    checks++; if (bus.state_o !== ST_FETCH) begin errors++; $display("FAIL final_state got %0d exp 0", bus.state_o); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control state machine for the multicycle MIPS core. It decodes the 6-bit opcode latched in the instruction register and sequences the shared datapath one step per cycle: PC/IR update, ALU source selection (including the 2-bit ALU srcB mux select), memory access, register write-back, branch and jump. The block sits between the instruction register and every datapath mux and write-enable. The ALU control decoder consumes its `aluop` output.

## Interface
- `MEM_TIMEOUT`, default 0: reserved, must be 0. Wait behaviour is chosen only by macro.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: IR[31:26], stable from DECODE through the end of the instruction.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory access completes this cycle. Used only with `MC_MEM_WAIT_EN`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: IR load enable.
- `regdst` out 1: destination register select, 0 = rt, 1 = rd.
- `memtoreg` out 1: write-back source select, 0 = ALUOut, 1 = MDR.
- `regwrite` out 1: register-file write enable.
- `alusrca` out 1: ALU A source select, 0 = PC, 1 = A register.
- `alusrcb` out 2: ALU B source select: 00 = B, 01 = constant 4, 10 = sign_imm, 11 = sign_imm<<2.
- `aluop` out 2: ALU operation class: 00 = add, 01 = sub, 10 = funct field.
- `pcsrc` out 2: next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen` out 1: PC load enable, equal to `pcwrite` | (`branch` & `zero`).
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `state_o` out 4: current state, for debug.

## Operation
- Moore machine. All outputs decode from the current state only, except `pcen`, which also uses `zero`.
- Opcodes:
  - LW = 100011
  - SW = 101011
  - RTYPE = 000000
  - BEQ = 000100
  - ADDI = 001000
  - J = 000010
- States and their asserted outputs. Every output not listed is 0.
  - FETCH: `irwrite`, `pcwrite`, `alusrcb`=01. Next state is DECODE.
  - DECODE: `alusrcb`=11, which precomputes the branch target. Next state depends on opcode:
    - LW or SW goes to MEMADR.
    - RTYPE goes to EXEC.
    - BEQ goes to BRANCH.
    - ADDI goes to ADDIEX.
    - J goes to JUMP.
    - Any other opcode pulses `illegal_op` and goes to FETCH.
  - MEMADR: `alusrca`=1, `alusrcb`=10. LW goes to MEMRD; SW goes to MEMWR.
  - MEMRD: `iord`=1. Next state is MEMWB.
  - MEMWB: `memtoreg`=1, `regwrite`=1. Next state is FETCH.
  - MEMWR: `iord`=1, `memwrite`=1. Next state is FETCH.
  - EXEC: `alusrca`=1, `alusrcb`=00, `aluop`=10. Next state is ALUWB.
  - ALUWB: `regdst`=1, `regwrite`=1. Next state is FETCH.
  - BRANCH: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1 (internal signal). Next state is FETCH.
  - ADDIEX: `alusrca`=1, `alusrcb`=10. Next state is ADDIWB.
  - ADDIWB: `regwrite`=1. Next state is FETCH.
  - JUMP: `pcsrc`=10, `pcwrite`=1. Next state is FETCH.
- Unreachable state encodings decode to all-zero outputs and go to FETCH on the next edge.

## Timing
- Reset:
  - `rst_n` low forces state to FETCH asynchronously.
  - While `rst_n` is low, all strobes are forced to 0: `irwrite`, `pcwrite`/`pcen`, `memwrite`, `regwrite`, `illegal_op`.
  - Selects show their FETCH values.
  - After release, the first rising edge with `rst_n` high executes FETCH.
- Reset asserted mid-instruction aborts it. No strobe fires after the falling edge of `rst_n`.
- Cycles per instruction without wait: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3, illegal 2.
- BEQ: `pcen` follows `zero` combinationally in the BRANCH cycle. `zero`=0 means the PC holds.
- `illegal_op` is high for exactly the DECODE cycle.

## Configuration
- `MC_MEM_WAIT_EN` defined:
  - FETCH, MEMRD and MEMWR hold their state while `mem_ready`=0.
  - During a FETCH hold, `irwrite` and `pcwrite` are gated to 0; both fire only in the cycle where `mem_ready`=1.
  - During a MEMWR hold, `memwrite` stays asserted until `mem_ready`=1.
- `MC_MEM_WAIT_EN` not defined: `mem_ready` is ignored and every state lasts one cycle.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum (4-bit)
  - opcode localparams
  - srcB encodings: SRCB_REG=00, SRCB_FOUR=01, SRCB_IMM=10, SRCB_IMM_SH2=11
  - aluop and pcsrc encodings
- One sub-module, `mc_ctrl_outdec`: combinational decode from state to the control word. The top holds the state register, next-state logic and the `pcen`/wait gating.

## Test plan
- Reset release, then opcode=100011 with no wait: state sequence FETCH→DECODE→MEMADR→MEMRD→MEMWB→FETCH. `alusrcb` is 01, 11, 10 over the first three states. `regwrite`=1 and `memtoreg`=1 only in cycle 5.
- opcode=000100 with `zero`=1: `pcen`=1 and `pcsrc`=01 in BRANCH (cycle 3). With `zero`=0, `pcen`=0 in that cycle.
- opcode=000010: JUMP in cycle 3 with `pcsrc`=10 and `pcen`=1. FETCH in cycle 4.
- opcode=111111: `illegal_op`=1 for one cycle in DECODE, then FETCH. No `regwrite` or `memwrite` pulse.
- With `MC_MEM_WAIT_EN`, SW with `mem_ready`=0 for 3 cycles in MEMWR: `memwrite` high for 4 cycles, and FETCH follows the cycle where `mem_ready`=1.
- `rst_n` pulled low during ALUWB: `regwrite` drops immediately and the state is FETCH.
